// File: rtl/gpr_wr_arbiter_if.sv
// Writeback request bundle for the GPR write-port arbiter: three requesters, one-hot-or-zero ready.
interface gpr_wr_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [2:0]          req_valid;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_data;
  logic [2:0]          req_ready;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/gpr_wr_arbiter.sv
// Arbitrates EX/MEM/muldiv writebacks onto the single GPR write port and tracks pending destinations.
// GPR_WR_ARB_RR_EN selects round-robin; otherwise fixed priority MEM > EX > muldiv.
module gpr_wr_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  gpr_wr_arbiter_if.slave   req,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] chk_addr_0,
  output logic              chk_busy_0,
  input  logic [ADDR_W-1:0] chk_addr_1,
  output logic              chk_busy_1,
  output logic              gpr_we,
  output logic [ADDR_W-1:0] gpr_wr_addr,
  output logic [DATA_W-1:0] gpr_wr_data,
  output logic              pend_any
);

  // First valid requester in the order a, b, c wins.
  function automatic logic [2:0] pick3(input logic [2:0] v, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] c);
    logic [2:0] g;
    g = '0;
    if (v[a])      g[a] = 1'b1;
    else if (v[b]) g[b] = 1'b1;
    else if (v[c]) g[c] = 1'b1;
    return g;
  endfunction

  logic [2:0]        grant_raw;
  logic [2:0]        grant;
  logic [1:0]        gnt_idx;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic [REG_NUM-1:0] pend_reg;

`ifdef GPR_WR_ARB_RR_EN
  logic [1:0] ptr_reg;

  always_comb begin
    case (ptr_reg)
      2'd0:    grant_raw = pick3(req.req_valid, 2'd1, 2'd2, 2'd0);
      2'd1:    grant_raw = pick3(req.req_valid, 2'd2, 2'd0, 2'd1);
      default: grant_raw = pick3(req.req_valid, 2'd0, 2'd1, 2'd2);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      ptr_reg <= 2'd2;
    else if (|grant)
      ptr_reg <= gnt_idx;
  end
`else
  always_comb grant_raw = pick3(req.req_valid, 2'd1, 2'd0, 2'd2);
`endif

  assign grant         = (reset || flush) ? 3'b000 : grant_raw;
  assign req.req_ready = grant;
  assign gnt_idx       = grant[1] ? 2'd1 : (grant[2] ? 2'd2 : 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      we_reg   <= 1'b0;
      addr_reg <= '0;
      data_reg <= '0;
    end else if (|grant) begin
      we_reg   <= 1'b1;
      addr_reg <= req.req_addr[gnt_idx*ADDR_W +: ADDR_W];
      data_reg <= req.req_data[gnt_idx*DATA_W +: DATA_W];
    end else begin
      we_reg   <= 1'b0;
    end
  end

  // A registered write is dropped as soon as reset is seen, not one edge later.
  assign gpr_we      = we_reg & ~reset;
  assign gpr_wr_addr = addr_reg;
  assign gpr_wr_data = data_reg;

  for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_pend
    logic set_hit;
    logic clr_hit;
    assign set_hit = rsv_valid && (rsv_addr == ADDR_W'(gi));
    assign clr_hit = gpr_we && (gpr_wr_addr == ADDR_W'(gi));

    always_ff @(posedge clk) begin
      if (reset || flush)
        pend_reg[gi] <= 1'b0;
      else if (set_hit)
        pend_reg[gi] <= 1'b1;
      else if (clr_hit)
        pend_reg[gi] <= 1'b0;
    end
  end

  // The in-flight write is bypassed by the register file, so it is not a hazard.
  assign chk_busy_0 = pend_reg[chk_addr_0] & ~(gpr_we && (gpr_wr_addr == chk_addr_0));
  assign chk_busy_1 = pend_reg[chk_addr_1] & ~(gpr_we && (gpr_wr_addr == chk_addr_1));
  assign pend_any   = |pend_reg;

endmodule

// File: tb/tb_gpr_wr_arbiter.sv
// Directed bench for gpr_wr_arbiter: expected GPR writes are queued at grant time and
// popped by an independent monitor whenever gpr_we is seen.
module tb_gpr_wr_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset, flush, rsv_valid;
  logic [AW-1:0] rsv_addr, chk_addr_0, chk_addr_1;
  logic          chk_busy_0, chk_busy_1, gpr_we, pend_any;
  logic [AW-1:0] gpr_wr_addr;
  logic [DW-1:0] gpr_wr_data;

  gpr_wr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  gpr_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .REG_NUM(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .req(bus),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .chk_addr_0(chk_addr_0), .chk_busy_0(chk_busy_0),
    .chk_addr_1(chk_addr_1), .chk_busy_1(chk_busy_1),
    .gpr_we(gpr_we), .gpr_wr_addr(gpr_wr_addr), .gpr_wr_data(gpr_wr_data),
    .pend_any(pend_any)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every committed GPR write must match the oldest expected one.
  always @(negedge clk) begin
    if (gpr_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%0h expected no write", gpr_wr_addr, gpr_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        $display("write: addr=%0d data=%0h (expected addr=%0d data=%0h)", gpr_wr_addr, gpr_wr_data, e.a, e.d);
        chk("wr_addr", 32'(gpr_wr_addr), 32'(e.a));
        chk("wr_data", gpr_wr_data, e.d);
      end
    end
  end

  logic [AW-1:0] tab_a [3];
  logic [DW-1:0] tab_d [3];
  int            seq   [6];
  int            g;
  int            g_after_rst;

  initial begin
    tab_a = '{5'd1, 5'd2, 5'd3};
    tab_d = '{32'h100, 32'h200, 32'h300};
`ifdef GPR_WR_ARB_RR_EN
    seq         = '{0, 1, 2, 0, 1, 2};
    g_after_rst = 0;
`else
    seq         = '{1, 1, 1, 1, 1, 1};
    g_after_rst = 1;
`endif
    reset = 1'b1; flush = 1'b0; rsv_valid = 1'b0; rsv_addr = '0;
    chk_addr_0 = '0; chk_addr_1 = '0;
    bus.req_valid = 3'b000; bus.req_addr = '0; bus.req_data = '0;

    // Reset: requests are ignored while reset is high
    tick(); bus.req_valid = 3'b111; settle();
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    tick(); reset = 1'b0; bus.req_valid = 3'b000;
    for (int i = 0; i < 3; i++) set_req(i, tab_a[i], tab_d[i]);
    settle();
    chk("rst_we", 32'(gpr_we), 0);
    chk("rst_addr", 32'(gpr_wr_addr), 0);
    chk("rst_data", gpr_wr_data, 0);
    chk("rst_pend_any", 32'(pend_any), 0);
    chk("rst_busy0", 32'(chk_busy_0), 0);

    // Contention: all three requesters held valid for six cycles
    for (int k = 0; k < 6; k++) begin
      tick(); bus.req_valid = 3'b111; settle();
      g = seq[k];
      chk($sformatf("contend_ready_%0d", k), 32'(bus.req_ready), 32'(3'b001 << g));
      push(tab_a[g], tab_d[g]);
    end
    tick(); bus.req_valid = 3'b000; settle();

    // Single write with one-cycle latency
    tick(); bus.req_valid = 3'b001; set_req(0, 5'd5, 32'hDEAD_BEEF); settle();
    chk("single_ready", 32'(bus.req_ready), 32'h1);
    push(5'd5, 32'hDEAD_BEEF);
    tick(); bus.req_valid = 3'b000; settle();
    chk("single_we", 32'(gpr_we), 1);
    chk("single_addr", 32'(gpr_wr_addr), 5);
    chk("single_data", gpr_wr_data, 32'hDEAD_BEEF);

    // Scoreboard: reserve r7, write r7, busy drops in the commit cycle
    tick(); rsv_valid = 1'b1; rsv_addr = 5'd7; chk_addr_0 = 5'd7; chk_addr_1 = 5'd8; settle();
    chk("sb_busy_pre", 32'(chk_busy_0), 0);
    tick(); rsv_valid = 1'b0; settle();
    chk("sb_busy_set", 32'(chk_busy_0), 1);
    chk("sb_pend_any", 32'(pend_any), 1);
    chk("sb_busy_other", 32'(chk_busy_1), 0);
    tick(); bus.req_valid = 3'b001; set_req(0, 5'd7, 32'h77); settle();
    chk("sb_ready", 32'(bus.req_ready), 32'h1);
    push(5'd7, 32'h77);
    tick(); bus.req_valid = 3'b000; settle();
    chk("sb_busy_inflight", 32'(chk_busy_0), 0);
    tick(); settle();
    chk("sb_busy_after", 32'(chk_busy_0), 0);
    chk("sb_pend_clear", 32'(pend_any), 0);

    // Re-reserve in the commit cycle: set wins over clear
    tick(); rsv_valid = 1'b1; rsv_addr = 5'd7; settle();
    tick(); rsv_valid = 1'b0; bus.req_valid = 3'b001; set_req(0, 5'd7, 32'h78); settle();
    chk("sb2_ready", 32'(bus.req_ready), 32'h1);
    push(5'd7, 32'h78);
    tick(); bus.req_valid = 3'b000; rsv_valid = 1'b1; rsv_addr = 5'd7; settle();
    chk("sb2_busy_inflight", 32'(chk_busy_0), 0);
    tick(); rsv_valid = 1'b0; settle();
    chk("sb2_set_wins", 32'(chk_busy_0), 1);

    // Flush: pending r3,r9 (plus r7); a registered write still commits
    tick(); rsv_valid = 1'b1; rsv_addr = 5'd3; settle();
    tick(); rsv_addr = 5'd9; bus.req_valid = 3'b001; set_req(0, 5'd3, 32'h33); settle();
    chk("fl_pre_ready", 32'(bus.req_ready), 32'h1);
    push(5'd3, 32'h33);
    tick(); rsv_addr = 5'd11; flush = 1'b1; bus.req_valid = 3'b010; set_req(1, 5'd9, 32'h99); settle();
    chk("fl_ready", 32'(bus.req_ready), 32'h0);
    chk("fl_we", 32'(gpr_we), 1);
    chk("fl_pend_before", 32'(pend_any), 1);
    tick(); flush = 1'b0; rsv_valid = 1'b0; chk_addr_0 = 5'd11; chk_addr_1 = 5'd9; settle();
    chk("fl_pend_any", 32'(pend_any), 0);
    chk("fl_busy_r11", 32'(chk_busy_0), 0);
    chk("fl_busy_r9", 32'(chk_busy_1), 0);
    chk("fl_post_ready", 32'(bus.req_ready), 32'h2);
    push(5'd9, 32'h99);
    tick(); bus.req_valid = 3'b000; settle();

    // Reset mid-operation: accepted write is discarded, pointer returns to 2
    tick(); bus.req_valid = 3'b001; set_req(0, 5'd4, 32'h44); settle();
    chk("mr_ready", 32'(bus.req_ready), 32'h1);
    tick(); bus.req_valid = 3'b000; reset = 1'b1; settle();
    chk("mr_we_n1", 32'(gpr_we), 0);
    tick(); reset = 1'b0; settle();
    chk("mr_we_n2", 32'(gpr_we), 0);
    chk("mr_pend_any", 32'(pend_any), 0);
    for (int i = 0; i < 3; i++) set_req(i, tab_a[i], tab_d[i]);
    tick(); bus.req_valid = 3'b111; settle();
    chk("mr_ptr_ready", 32'(bus.req_ready), 32'(3'b001 << g_after_rst));
    push(tab_a[g_after_rst], tab_d[g_after_rst]);
    tick(); bus.req_valid = 3'b000; settle();
    tick(); tick(); settle();
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
